// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch and data) for a single memory port.
// Data requests win contention unless fetch has been starved STARVE_MAX times;
// one transaction is outstanding at most, tracked by an IDLE/ISSUE/WAIT FSM.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            cancel_q, cancel_d;
  logic            owner_fetch_q, owner_fetch_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            fetch_win, data_win;
  logic            starve_full;

  assign starve_full = (starve_q == CW'(STARVE_MAX));

  // Arbitration, payload capture, starvation/cancel tracking and completion routing
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    cancel_d      = cancel_q;
    owner_fetch_d = owner_fetch_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_rvalid_d   = 1'b0;
    d_rvalid_d    = 1'b0;
    fetch_win     = 1'b0;
    data_win      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flushing fetch is not eligible; data may still win in that cycle.
        if (if_req && !if_flush && (!d_req || starve_full)) begin
          fetch_win     = 1'b1;
          owner_fetch_d = 1'b1;
          we_d          = 1'b0;
          addr_d        = if_addr;
          wdata_d       = 32'h0;
          wstrb_d       = 4'h0;
          starve_d      = '0;
          cancel_d      = 1'b0;
          state_d       = ISSUE;
        end else if (d_req) begin
          data_win      = 1'b1;
          owner_fetch_d = 1'b0;
          we_d          = d_we;
          addr_d        = d_addr;
          wdata_d       = d_wdata;
          wstrb_d       = d_wstrb;
          cancel_d      = 1'b0;
          if (if_req && !starve_full) starve_d = starve_q + CW'(1);
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_fetch_q && if_flush) cancel_d = 1'b1;
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (owner_fetch_q && if_flush) cancel_d = 1'b1;
        if (mem_rvalid) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          // A flush arriving with the response still cancels it.
          if (owner_fetch_q) begin
            if (!(cancel_q || if_flush)) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata;
            end
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      cancel_q      <= 1'b0;
      owner_fetch_q <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
      if_rdata_q    <= 32'h0;
      d_rdata_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      cancel_q      <= cancel_d;
      owner_fetch_q <= owner_fetch_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  // Grants are combinational in IDLE and held low while reset is asserted
  assign if_gnt    = fetch_win & reset_n;
  assign d_gnt     = data_win & reset_n;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level reference model predicts
// grants and memory payloads; expected responses go to queues drained by a monitor.
module tb_mem_arbiter;

  localparam int unsigned SMAX   = 4;
  localparam int          NCYC   = 4000;
  localparam int          NDRAIN = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    int          due;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses when rvalid is seen, checks rdata hold otherwise
  logic [31:0] if_last, d_last;
  logic        d_last_ok;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      fq.delete();
      dq.delete();
      if_last   = 32'h0;
      d_last    = 32'h0;
      d_last_ok = 1'b1;
    end else begin
      if (if_rvalid) begin
        chk("if_rvalid_expected", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) begin
          e = fq.pop_front();
          chk("if_rdata", if_rdata, e.data);
          chk("if_rvalid_cycle", 32'(cyc), 32'(e.due));
          if_last = e.data;
        end
      end else begin
        chk("if_rdata_hold", if_rdata, if_last);
        if (fq.size() != 0 && fq[0].due < cyc) begin
          chk("if_rvalid_missing", 32'(if_rvalid), 32'd1);
          void'(fq.pop_front());
        end
      end
      if (d_rvalid) begin
        chk("d_rvalid_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          if (e.chk) chk("d_rdata", d_rdata, e.data);
          chk("d_rvalid_cycle", 32'(cyc), 32'(e.due));
          d_last    = e.data;
          d_last_ok = e.chk;
        end
      end else begin
        if (d_last_ok) chk("d_rdata_hold", d_rdata, d_last);
        if (dq.size() != 0 && dq[0].due < cyc) begin
          chk("d_rvalid_missing", 32'(d_rvalid), 32'd1);
          void'(dq.pop_front());
        end
      end
    end
  end

  // Reference model state: transaction phase (0 none, 1 awaiting accept, 2 awaiting response)
  int          ph;
  int unsigned starve;
  logic        cancel;
  logic        cur_fetch, cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        if_granted, d_granted;
  logic        exp_fg, exp_dg;
  int          post, n_forced, n_cancel, n_write, n_fetch_done;
  logic        rst_done;

  initial begin
    exp_t e;
    int   p;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    ph = 0; starve = 0; cancel = 1'b0;
    cur_fetch = 1'b0; cur_we = 1'b0; cur_addr = 32'h0; cur_wdata = 32'h0; cur_wstrb = 4'h0;
    if_granted = 1'b0; d_granted = 1'b0;
    post = 0; n_forced = 0; n_cancel = 0; n_write = 0; n_fetch_done = 0; rst_done = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      // Reset control: initial reset, then one reset while a transaction waits for data
      if (n < 3) reset_n = 1'b0;
      else if (n >= 1500 && !rst_done && ph == 2) begin
        reset_n  = 1'b0;
        rst_done = 1'b1;
        post     = 4;
      end else reset_n = 1'b1;

      if (!reset_n || post > 0) begin
        // Quiet period; after reset, a stale response is presented and must be ignored
        if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
        mem_ready  = 1'($urandom % 2);
        mem_rvalid = reset_n;
        mem_rdata  = $urandom;
        if (reset_n) post--;
      end else begin
        p = (n >= NCYC - NDRAIN) ? 0 : 7;
        if (!(if_req && !if_granted)) begin
          if_req  = ($urandom % 10) < p;
          if_addr = $urandom;
        end
        if (!(d_req && !d_granted)) begin
          d_req   = ($urandom % 10) < p;
          d_we    = 1'($urandom % 2);
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_wstrb = 4'($urandom % 16);
        end
        if (n >= NCYC - NDRAIN) begin
          if_flush = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1;
        end else begin
          if_flush   = ($urandom % 25) == 0;
          mem_ready  = 1'($urandom % 2);
          mem_rvalid = ($urandom % 5) < 2;
        end
        mem_rdata = $urandom;
      end

      @(negedge clk);
      if_granted = 1'b0;
      d_granted  = 1'b0;
      if (!reset_n) begin
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        ph = 0; starve = 0; cancel = 1'b0;
      end else begin
        exp_fg = 1'b0;
        exp_dg = 1'b0;
        if (ph == 0) begin
          exp_fg = if_req && !if_flush && (!d_req || starve == SMAX);
          exp_dg = d_req && !exp_fg;
        end
        chk("if_gnt", 32'(if_gnt), 32'(exp_fg));
        chk("d_gnt", 32'(d_gnt), 32'(exp_dg));
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("mem_req", 32'(mem_req), 32'(ph == 1));
        if (ph == 1) begin
          chk("mem_addr", mem_addr, cur_addr);
          chk("mem_we", 32'(mem_we), 32'(cur_we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(cur_wstrb));
          if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
        end else begin
          chk("mem_we_outside_issue", 32'(mem_we), 32'd0);
        end

        case (ph)
          0: begin
            if (exp_fg) begin
              if (d_req) n_forced++;
              cur_fetch = 1'b1; cur_we = 1'b0; cur_addr = if_addr;
              cur_wdata = 32'h0; cur_wstrb = 4'h0;
              starve = 0; cancel = 1'b0; ph = 1; if_granted = 1'b1;
            end else if (exp_dg) begin
              cur_fetch = 1'b0; cur_we = d_we; cur_addr = d_addr;
              cur_wdata = d_wdata; cur_wstrb = d_wstrb;
              if (if_req && starve < SMAX) starve++;
              cancel = 1'b0; ph = 1; d_granted = 1'b1;
            end
          end
          1: begin
            if (cur_fetch && if_flush) cancel = 1'b1;
            if (mem_ready) ph = 2;
          end
          default: begin
            if (cur_fetch && if_flush) cancel = 1'b1;
            if (mem_rvalid) begin
              ph     = 0;
              e.data = mem_rdata;
              e.due  = cyc + 1;
              if (!cur_fetch) begin
                e.chk = !cur_we;
                if (cur_we) n_write++;
                dq.push_back(e);
              end else if (!cancel) begin
                e.chk = 1'b1;
                n_fetch_done++;
                fq.push_back(e);
              end else n_cancel++;
              cancel = 1'b0;
            end
          end
        endcase
      end
    end

    repeat (3) @(negedge clk);
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("data_queue_drained", 32'(dq.size()), 32'd0);
    chk("model_idle_at_end", 32'(ph), 32'd0);
    chk("busy_at_end", 32'(busy), 32'd0);
    chk("forced_fetch_wins_seen", 32'(n_forced > 0), 32'd1);
    chk("cancelled_fetches_seen", 32'(n_cancel > 0), 32'd1);
    chk("writes_seen", 32'(n_write > 0), 32'd1);
    chk("fetch_reads_seen", 32'(n_fetch_done > 0), 32'd1);
    chk("mid_reset_applied", 32'(rst_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while a fetch waits before fetch is forced to win.
REQ-002 clk  in  1  core clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  reset: one clock, asynchronous assertion, active-low.
REQ-004 if_req  in  1, if_addr  in  32: fetch request and word address; held stable until if_gnt.
REQ-005 if_flush  in  1  branch redirect; cancels any outstanding fetch.
REQ-006 if_gnt  out  1, if_rvalid  out  1, if_rdata  out  32: fetch accept and fetch response.
REQ-007 d_req  in  1, d_we  in  1, d_addr  in  32, d_wdata  in  32, d_wstrb  in  4: data request, held stable until d_gnt.
REQ-008 d_gnt  out  1, d_rvalid  out  1, d_rdata  out  32: data accept and data completion (d_rvalid also pulses for writes).
REQ-009 mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_wstrb  out  4: request to the single memory port.
REQ-010 mem_ready  in  1, mem_rvalid  in  1, mem_rdata  in  32: memory accept and memory response.
REQ-011 busy  out  1  high when state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, ISSUE and WAIT, with one transaction outstanding at most.
REQ-013 In IDLE, gnt SHALL be combinational and go to at most one winner; the payload is latched and the FSM goes to ISSUE on that edge.
REQ-014 Winner when only one request is active: that requester.
REQ-015 Winner when both are active: data, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_MAX) on a data grant while if_req=1.
REQ-017 starve_cnt SHALL clear to 0 on any fetch grant.
REQ-018 if_flush=1 in IDLE SHALL force if_gnt=0 in that cycle; data may still be granted.
REQ-019 In ISSUE, mem_req=1 with the latched payload; mem_we/mem_wstrb are 0 for fetches.
REQ-020 ISSUE SHALL go to WAIT on an edge where mem_ready=1, and otherwise hold with the payload stable.
REQ-021 In WAIT, on mem_rvalid=1 the FSM SHALL go to IDLE, register mem_rdata into the owner's rdata, and pulse the owner's rvalid for exactly one cycle on the next cycle.
REQ-022 Minimum transaction spacing SHALL be 3 cycles: grant, issue, response.
REQ-023 if_flush=1 while fetch owns ISSUE or WAIT SHALL set a cancel flag: the transaction completes on the memory side, if_rvalid stays 0, and the flag clears on return to IDLE.
REQ-024 if_flush SHALL have no effect on a data transaction.
REQ-025 mem_rvalid in IDLE or ISSUE SHALL be ignored.
REQ-026 mem_ready outside ISSUE SHALL be ignored.
REQ-027 rdata outputs SHALL hold their last value when rvalid=0.
REQ-028 d_rdata after a write completion is don't-care.
REQ-029 An rvalid pulse and a new gnt MAY occur in the same cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, starve_cnt=0, cancel=0, all gnt/rvalid/mem_req/mem_we=0, and all address/data/wstrb registers to 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid after release is ignored per REQ-025.
REQ-032 The first grant is possible in the first cycle after reset_n rises.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid the cycle after with rdata=0xDEADBEEF -> if_gnt cycle 0, mem_req cycle 1, if_rvalid=1 with 0xDEADBEEF cycle 3.
REQ-034 Contention: both requests held, STARVE_MAX=4 -> grant order D,D,D,D,F,D,...; starve_cnt returns to 0 after the F.
REQ-035 Write: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_wstrb=0x3 -> mem_we=1, mem_wstrb=0x3, and d_rvalid pulses once.
REQ-036 Backpressure: mem_ready=0 for 5 cycles in ISSUE -> mem_req and mem_addr stay stable and busy=1 throughout.
REQ-037 Flush: if_flush pulses in WAIT of a fetch -> no if_rvalid; the next if_req is granted normally.
REQ-038 Reset in WAIT, then mem_rvalid=1 after release -> no rvalid on either port; state stays IDLE.
